// File: rtl/ntt_collect_pkg.sv
// Shared types and helpers for the NTT result collector: FSM state encoding,
// default geometry and the two per-word helpers (final reduction, address map).
package ntt_collect_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int MAX_DEPTH_DEF  = 10;
  localparam int LANE_DEPTH_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DRAIN     = 2'd3
  } state_e;

  // Single conditional subtraction; inputs >= 2q deliberately stay unreduced.
  function automatic logic [DATA_W_DEF-1:0] cond_sub(input logic [DATA_W_DEF-1:0] x,
                                                      input logic [DATA_W_DEF-1:0] q_ext);
    if (x >= q_ext) begin
      cond_sub = x - q_ext;
    end else begin
      cond_sub = x;
    end
  endfunction

  // Word m of the interleaved stream lands at lane*(N/L) + m/L.
  function automatic logic [MAX_DEPTH_DEF-1:0] addr_map(input logic [MAX_DEPTH_DEF-1:0] m,
                                                         input logic [3:0] depth,
                                                         input logic [3:0] lane_depth);
    logic [MAX_DEPTH_DEF-1:0] lane;
    logic [MAX_DEPTH_DEF-1:0] slot;
    lane     = m & ((MAX_DEPTH_DEF'(1) << lane_depth) - MAX_DEPTH_DEF'(1));
    slot     = m >> lane_depth;
    addr_map = (lane << (depth - lane_depth)) | slot;
  endfunction

endpackage

// File: rtl/ntt_sdp_ram.sv
// Simple dual-port buffer: one write port, one registered read port.
// The read register only updates on rd_en_i, so it doubles as the output
// holding stage of the collector.
module ntt_sdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // Storage array write; contents intentionally survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read, held while no new read is requested.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_data_q <= {DATA_W{1'b0}};
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ntt_result_collector.sv
// Collects the NTT core's interleaved result stream into a buffer at natural
// indices (with the final mod-q subtraction), then replays coefficients 0..N-1
// on a valid/ready stream. The buffer's read register acts as the one-entry
// prefetch stage: a new read is issued whenever that stage is empty or being
// consumed, giving one word per cycle and stable data under backpressure.
module ntt_result_collector
  import ntt_collect_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int Q_W        = 16,
  parameter int MAX_DEPTH  = MAX_DEPTH_DEF,
  parameter int MIN_DEPTH  = 6,
  parameter int LANE_DEPTH = LANE_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic [3:0]        ring_depth,
  input  logic [Q_W-1:0]    q,
  input  logic              core_done,
  input  logic              core_valid,
  input  logic [DATA_W-1:0] core_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  localparam logic [MAX_DEPTH-1:0] ONE = MAX_DEPTH'(1);

  state_e               state_q, state_d;
  logic [3:0]           depth_q, depth_d;
  logic [Q_W-1:0]       q_q, q_d;
  logic [MAX_DEPTH-1:0] last_idx_q, last_idx_d;
  logic [MAX_DEPTH-1:0] m_q, m_d;
  logic [MAX_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                 rd_more_q, rd_more_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic                 legal_s;
  logic                 wr_en_s;
  logic                 rd_en_s;
  logic [MAX_DEPTH-1:0] wr_addr_s;
  logic [DATA_W-1:0]    wr_data_s;
  logic [DATA_W-1:0]    q_ext_s;

  assign legal_s   = (ring_depth >= 4'(MIN_DEPTH)) && (ring_depth <= 4'(MAX_DEPTH));
  assign q_ext_s   = {{(DATA_W-Q_W){1'b0}}, q_q};
  assign wr_addr_s = addr_map(m_q, depth_q, 4'(LANE_DEPTH));
  assign wr_data_s = cond_sub(core_dout, q_ext_s);

  // Next-state, counter and output-stage control for the collector FSM.
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    q_d         = q_q;
    last_idx_d  = last_idx_q;
    m_d         = m_q;
    rd_ptr_d    = rd_ptr_q;
    rd_more_d   = rd_more_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm && legal_s) begin
          depth_d    = ring_depth;
          q_d        = q;
          last_idx_d = MAX_DEPTH'((32'd1 << ring_depth) - 32'd1);
          m_d        = {MAX_DEPTH{1'b0}};
          err_d      = 1'b0;
          state_d    = ST_WAIT_DONE;
        end else if (arm) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        // core_valid here (including the done cycle) belongs to no capture.
        if (core_done) begin
          m_d     = {MAX_DEPTH{1'b0}};
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_CAPTURE: begin
        if (core_valid) begin
          wr_en_s = 1'b1;
          m_d     = m_q + ONE;
          if (m_q == last_idx_q) begin
            rd_ptr_d  = {MAX_DEPTH{1'b0}};
            rd_more_d = 1'b1;
            state_d   = ST_DRAIN;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (core_valid) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        rd_en_s = rd_more_q && (!out_valid_q || out_ready);
        if (rd_en_s) begin
          out_valid_d = 1'b1;
          out_last_d  = (rd_ptr_q == last_idx_q);
          rd_ptr_d    = rd_ptr_q + ONE;
          rd_more_d   = (rd_ptr_q != last_idx_q);
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (arm && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      depth_q     <= 4'd0;
      q_q         <= {Q_W{1'b0}};
      last_idx_q  <= {MAX_DEPTH{1'b0}};
      m_q         <= {MAX_DEPTH{1'b0}};
      rd_ptr_q    <= {MAX_DEPTH{1'b0}};
      rd_more_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      q_q         <= q_d;
      last_idx_q  <= last_idx_d;
      m_q         <= m_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_more_q   <= rd_more_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  ntt_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (MAX_DEPTH)
  ) u_buf (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_addr_s),
    .wr_data_i (wr_data_s),
    .rd_en_i   (rd_en_s),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (out_data)
  );

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ntt_result_collector.sv
// Self-checking bench for ntt_result_collector: table-driven arm/reduction
// vectors, hand sequences for timing corners, randomized streams against a
// natural-order reference model.
module tb_ntt_result_collector;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic [3:0]  ring_depth = 4'd0;
  logic [15:0] q = 16'd0;
  logic        core_done = 1'b0;
  logic        core_valid = 1'b0;
  logic [31:0] core_dout = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] words [1024];
  logic [31:0] exp_d [1024];
  logic [31:0] got   [1024];

  typedef struct {
    int   depth;
    logic rst_before;
    logic exp_err;
    logic exp_busy;
  } arm_vec_t;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dexp;
  } red_vec_t;

  arm_vec_t atab [8];
  red_vec_t rtab [4];

  ntt_result_collector dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .ring_depth (ring_depth),
    .q          (q),
    .core_done  (core_done),
    .core_valid (core_valid),
    .core_dout  (core_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic start(input int depth, input int qv);
    arm = 1'b1;
    ring_depth = 4'(depth);
    q = 16'(qv);
    tick();
    arm = 1'b0;
    q = 16'd0;  // value must have been latched on arm
  endtask

  // Reference model: natural index of stream word m, and its reduced value.
  task automatic build_model(input int nw, input int qv);
    logic [31:0] qx;
    int idx;
    qx = 32'(qv);
    for (int m = 0; m < nw; m++) begin
      idx = (m % L) * (nw / L) + m / L;
      exp_d[idx] = (words[m] >= qx) ? (words[m] - qx) : words[m];
    end
  endtask

  // Drive pre-done junk, the done cycle, then the stream with bubbles.
  task automatic feed(input int nw, input int bubble_pct, input int pre_junk, input int stop_after);
    int m;
    int guard;
    for (int i = 0; i < pre_junk; i++) begin
      core_valid = 1'b1;
      core_dout = $urandom;
      tick();
    end
    core_done = 1'b1;
    core_valid = 1'b1;
    core_dout = 32'hDEAD_BEEF;
    tick();
    core_done = 1'b0;
    m = 0;
    guard = 0;
    while (m < nw && guard < nw * 20) begin
      guard++;
      if ($urandom_range(0, 99) < bubble_pct) begin
        core_valid = 1'b0;
        core_dout = $urandom;
        tick();
      end else begin
        core_valid = 1'b1;
        core_dout = words[m];
        tick();
        m++;
        if (m == stop_after) begin
          core_valid = 1'b0;
          return;
        end
      end
    end
    core_valid = 1'b0;
    if (m < nw) check("feed_budget", 64'(m), 64'(nw));
  endtask

  task automatic drain(input int nw, input int ready_pct, input int extra_at, input logic exp_err);
    int k;
    int cyc;
    logic stalled;
    logic [31:0] prev_data;
    logic prev_last;
    logic rdy;
    check("lat_not_yet", 64'(out_valid), 64'd0);
    tick();
    check("lat_first_valid", 64'(out_valid), 64'd1);
    k = 0;
    cyc = 0;
    stalled = 1'b0;
    prev_data = 32'd0;
    prev_last = 1'b0;
    while (k < nw && cyc < nw * 10 + 50) begin
      core_valid = (cyc == extra_at);
      core_dout = $urandom;
      rdy = ($urandom_range(0, 99) < ready_pct);
      out_ready = rdy;
      if (ready_pct >= 100) check("throughput_valid", 64'(out_valid), 64'd1);
      if (stalled) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(prev_data));
        check("hold_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && rdy) begin
        got[k] = out_data;
        check($sformatf("data[%0d]", k), 64'(out_data), 64'(exp_d[k]));
        check($sformatf("last[%0d]", k), 64'(out_last), 64'(k == nw - 1));
        k++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
        prev_data = out_data;
        prev_last = out_last;
      end
      tick();
      cyc++;
    end
    core_valid = 1'b0;
    out_ready = 1'b0;
    if (k < nw) check("drain_budget", 64'(k), 64'(nw));
    check("end_valid_low", 64'(out_valid), 64'd0);
    check("end_busy_low", 64'(busy), 64'd0);
    check("end_err", 64'(err), 64'(exp_err));
  endtask

  initial begin
    int e;
    atab[0] = '{5,  1'b1, 1'b1, 1'b0};
    atab[1] = '{11, 1'b0, 1'b1, 1'b0};
    atab[2] = '{9,  1'b0, 1'b0, 1'b1};
    atab[3] = '{9,  1'b0, 1'b1, 1'b1};
    atab[4] = '{15, 1'b1, 1'b1, 1'b0};
    atab[5] = '{6,  1'b0, 1'b0, 1'b1};
    atab[6] = '{0,  1'b1, 1'b1, 1'b0};
    atab[7] = '{10, 1'b0, 1'b0, 1'b1};
    rtab[0] = '{32'd12288, 32'd12288};
    rtab[1] = '{32'd12289, 32'd0};
    rtab[2] = '{32'd12290, 32'd1};
    rtab[3] = '{32'd24577, 32'd12288};

    // Reset state
    do_reset();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);

    // Arm legality and arm-while-busy
    for (int i = 0; i < 8; i++) begin
      if (atab[i].rst_before) do_reset();
      start(atab[i].depth, 12289);
      check($sformatf("arm%0d_err", i), 64'(err), 64'(atab[i].exp_err));
      check($sformatf("arm%0d_busy", i), 64'(busy), 64'(atab[i].exp_busy));
    end
    do_reset();

    // N=512 identity stream, no bubbles, always ready
    for (int m = 0; m < 512; m++) words[m] = 32'(m);
    build_model(512, 12289);
    start(9, 12289);
    feed(512, 0, 0, -1);
    drain(512, 100, -1, 1'b0);
    for (int k = 0; k < 512; k++) begin
      e = (k < 256) ? 2 * k : 2 * (k - 256) + 1;
      check($sformatf("deint[%0d]", k), 64'(got[k]), 64'(e));
    end

    // Reduction boundary table, N=64
    for (int m = 0; m < 64; m++) words[m] = $urandom_range(0, 12288);
    for (int i = 0; i < 4; i++) words[i] = rtab[i].din;
    build_model(64, 12289);
    start(6, 12289);
    feed(64, 10, 0, -1);
    drain(64, 100, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reduce%0d", i), 64'(got[(i % L) * 32 + i / L]), 64'(rtab[i].dexp));
    end

    // Backpressure, N=64
    for (int m = 0; m < 64; m++) words[m] = $urandom_range(0, 3 * 7681);
    build_model(64, 7681);
    start(6, 7681);
    feed(64, 25, 0, -1);
    drain(64, 50, -1, 1'b0);

    // Largest ring, random q, bubbles and backpressure
    begin
      int qr;
      qr = $urandom_range(1, 65535);
      for (int m = 0; m < 1024; m++) words[m] = $urandom_range(0, 3 * qr);
      build_model(1024, qr);
      start(10, qr);
      feed(1024, 20, 0, -1);
      drain(1024, 70, -1, 1'b0);
    end

    // Pre-done junk and an overflow word during drain
    for (int m = 0; m < 64; m++) words[m] = $urandom;
    build_model(64, 40961);
    start(6, 40961);
    feed(64, 0, 3, -1);
    drain(64, 100, 10, 1'b1);

    // Reset mid-capture, then a clean full operation
    for (int m = 0; m < 512; m++) words[m] = $urandom_range(0, 2 * 12289);
    start(9, 12289);
    feed(512, 0, 0, 100);
    do_reset();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    for (int m = 0; m < 512; m++) words[m] = $urandom_range(0, 2 * 3329);
    build_model(512, 3329);
    start(9, 3329);
    feed(512, 5, 0, -1);
    drain(512, 90, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
